full_adder: RTL and testbench

- Adder cell block containing one half-adder path and one full-adder path over the same operands.
- The half-adder path computes a + b; the full-adder path computes a + b + c.
- Each path provides combinational outputs and a one-cycle registered copy.
- Used as the primitive arithmetic cell of the datapath. At WIDTH=1 it is the classic single-bit half adder and full adder.

---
 rtl/full_adder.sv | 85 ++++++++
 tb/tb_full_adder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Adder cell: half-adder path (a+b) and full-adder path (a+b+c), each with
// combinational outputs and an enable-gated registered copy.

module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);
  assign s  = x ^ y;
  assign co = x & y;
endmodule

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0;
  logic c0;
  logic c1;

  // Two half-adder cells plus an OR on the carries.
  ha_cell u_ha0 (.x(x),  .y(y),  .s(s0), .co(c0));
  ha_cell u_ha1 (.x(s0), .y(ci), .s(s),  .co(c1));

  assign co = c0 | c1;
endmodule

module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum1,
  output logic             carry1,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic [WIDTH-1:0] sum1_q,
  output logic             carry1_q
);
  logic [WIDTH:0] hc;
  logic [WIDTH:0] fc;

  assign fc[0] = c;
  assign hc[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      ha_cell u_ha (.x(a[i]), .y(b[i]), .s(sum[i]), .co(hc[i+1]));
    end else begin : g_rip
      fa_cell u_fa (.x(a[i]), .y(b[i]), .ci(hc[i]), .s(sum[i]), .co(hc[i+1]));
    end
    fa_cell u_fa1 (.x(a[i]), .y(b[i]), .ci(fc[i]), .s(sum1[i]), .co(fc[i+1]));
  end

  assign carry  = hc[WIDTH];
  assign carry1 = fc[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q    <= '0;
      carry_q  <= 1'b0;
      sum1_q   <= '0;
      carry1_q <= 1'b0;
    end else if (en) begin
      sum_q    <= sum;
      carry_q  <= carry;
      sum1_q   <= sum1;
      carry1_q <= carry1;
    end
  end

  // hc[0] only exists to keep the carry vector uniformly indexed.
  logic unused;
  assign unused = hc[0];
endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder at WIDTH=1 and WIDTH=8.

module tb_full_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       a1, b1, c1;
  logic [7:0] a8, b8;
  logic       c8;

  logic       s1_sum, s1_carry, s1_sum1, s1_carry1;
  logic       s1_sum_q, s1_carry_q, s1_sum1_q, s1_carry1_q;
  logic [7:0] s8_sum, s8_sum1, s8_sum_q, s8_sum1_q;
  logic       s8_carry, s8_carry1, s8_carry_q, s8_carry1_q;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .en(en),
    .sum(s1_sum), .carry(s1_carry), .sum1(s1_sum1), .carry1(s1_carry1),
    .sum_q(s1_sum_q), .carry_q(s1_carry_q), .sum1_q(s1_sum1_q), .carry1_q(s1_carry1_q)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .en(en),
    .sum(s8_sum), .carry(s8_carry), .sum1(s8_sum1), .carry1(s8_carry1),
    .sum_q(s8_sum_q), .carry_q(s8_carry_q), .sum1_q(s8_sum1_q), .carry1_q(s8_carry1_q)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] s, input logic co,
                        input logic [7:0] s1, input logic co1);
    check({tag, ".sum"},    64'(s8_sum),    64'(s));
    check({tag, ".carry"},  64'(s8_carry),  64'(co));
    check({tag, ".sum1"},   64'(s8_sum1),   64'(s1));
    check({tag, ".carry1"}, 64'(s8_carry1), 64'(co1));
  endtask

  task automatic check8q(input string tag, input logic [7:0] s, input logic co,
                         input logic [7:0] s1, input logic co1);
    check({tag, ".sum_q"},    64'(s8_sum_q),    64'(s));
    check({tag, ".carry_q"},  64'(s8_carry_q),  64'(co));
    check({tag, ".sum1_q"},   64'(s8_sum1_q),   64'(s1));
    check({tag, ".carry1_q"}, 64'(s8_carry1_q), 64'(co1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {a, b, c, sum, carry, sum1, carry1}, hand-computed
  logic [6:0] vec [8] = '{
    7'b000_0000, 7'b001_0010, 7'b010_1010, 7'b011_1001,
    7'b100_1010, 7'b101_1001, 7'b110_0101, 7'b111_0111
  };

  initial begin
    rst = 1'b1; en = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b1;
    tick();
    check("rst1.q", 64'({s1_sum_q, s1_carry_q, s1_sum1_q, s1_carry1_q}), 64'(0));
    check8q("rst8", 8'h00, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic [6:0] v;
      v = vec[i];
      a1 = v[6]; b1 = v[5]; c1 = v[4];
      #1;
      check($sformatf("w1[%0d].sum", i),    64'(s1_sum),    64'(v[3]));
      check($sformatf("w1[%0d].carry", i),  64'(s1_carry),  64'(v[2]));
      check($sformatf("w1[%0d].sum1", i),   64'(s1_sum1),   64'(v[1]));
      check($sformatf("w1[%0d].carry1", i), 64'(s1_carry1), 64'(v[0]));
    end

    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; en = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b1;
    #1;
    check8("ff01", 8'h00, 1'b1, 8'h01, 1'b1);
    check8q("pre_load", 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    check("w1.q", 64'({s1_sum_q, s1_carry_q, s1_sum1_q, s1_carry1_q}), 64'(4'b0111));
    check8q("load", 8'h00, 1'b1, 8'h01, 1'b1);

    @(negedge clk);
    en = 1'b0; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    #1;
    check8("1234", 8'h46, 1'b0, 8'h46, 1'b0);
    tick();
    check8q("hold", 8'h00, 1'b1, 8'h01, 1'b1);

    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    #1;
    check8("wrap", 8'hFE, 1'b1, 8'hFF, 1'b1);

    @(negedge clk);
    en = 1'b1; a8 = 8'h80; b8 = 8'h80; c8 = 1'b1;
    tick();
    check8q("load2", 8'h00, 1'b1, 8'h01, 1'b1);

    @(negedge clk);
    rst = 1'b1;
    tick();
    check8q("rst_mid", 8'h00, 1'b0, 8'h00, 1'b0);
    check8("rst_comb", 8'h00, 1'b1, 8'h01, 1'b1);

    @(negedge clk);
    rst = 1'b0; a8 = 8'h0F; b8 = 8'h01; c8 = 1'b0;
    #1;
    check8q("post_rst_pre", 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    check8q("reload", 8'h10, 1'b0, 8'h10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
